// File: rtl/alu_commit_arbiter_if.sv
// Core sizing constants plus the commit-arbiter bus bundle.
// Carries the ALU commit side, the write-back port and the error/trap port.
// The master modport is the arbiter; the slave modport is the ALUs and consumers.
package core_config_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
endpackage

interface alu_commit_arbiter_if #(
    parameter int N_PORTS    = 4,
    parameter int XLEN       = core_config_pkg::XLEN,
    parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W,
    parameter int SRC_W      = $clog2(N_PORTS)
);
    logic [N_PORTS*XLEN-1:0]       alu_res;
    logic [N_PORTS*REG_ADDR_W-1:0] alu_rd;
    logic [N_PORTS-1:0]            alu_valid;
    logic [N_PORTS-1:0]            alu_error;
    logic [N_PORTS-1:0]            alu_clear;
    logic                          flush;
    logic                          wb_ready;
    logic                          wb_en;
    logic [REG_ADDR_W-1:0]         wb_rd;
    logic [XLEN-1:0]               wb_data;
    logic [SRC_W-1:0]              wb_src;
    logic                          err_valid;
    logic [SRC_W-1:0]              err_src;
    logic [REG_ADDR_W-1:0]         err_rd;

    modport master (
        input  alu_res, alu_rd, alu_valid, alu_error, flush, wb_ready,
        output alu_clear, wb_en, wb_rd, wb_data, wb_src, err_valid, err_src, err_rd
    );

    modport slave (
        output alu_res, alu_rd, alu_valid, alu_error, flush, wb_ready,
        input  alu_clear, wb_en, wb_rd, wb_data, wb_src, err_valid, err_src, err_rd
    );
endinterface

// File: rtl/alu_commit_arbiter.sv
// Round-robin arbiter sharing one write-back port among N_PORTS ALUs; errors go to a trap port.
// Latency: ALU valid at cycle T -> wb_en at T+1; one commit per cycle sustained.
// Backpressure: hold stage stalls while FULL && !wb_ready (no grants, no clears). Optional: ALU_COMMIT_X0_DROP_EN.
module alu_commit_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int XLEN       = core_config_pkg::XLEN,
    parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W,
    parameter int SRC_W      = $clog2(N_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_commit_arbiter_if.master bus
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                  state;
    logic [SRC_W-1:0]        rr_ptr;
    logic                    can_accept;
    logic                    scan_hit;
    logic                    grant;
    logic [SRC_W-1:0]        grant_idx;
    logic [SRC_W-1:0]        rr_next;
    logic [XLEN-1:0]         g_res;
    logic [REG_ADDR_W-1:0]   g_rd;
    logic                    g_err;
    logic                    x0_drop;

    assign can_accept = (state == EMPTY) || bus.wb_ready;
    assign grant      = scan_hit && can_accept && !bus.flush;
    assign g_res      = bus.alu_res[int'(grant_idx)*XLEN +: XLEN];
    assign g_rd       = bus.alu_rd[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign g_err      = bus.alu_error[grant_idx];
    assign rr_next    = (grant_idx == SRC_W'(N_PORTS-1)) ? '0 : grant_idx + 1'b1;
    assign bus.wb_en  = (state == FULL);

`ifdef ALU_COMMIT_X0_DROP_EN
    // x0 writes are architecturally dead: grant and clear them but never present them.
    assign x0_drop = (g_rd == '0);
`else
    assign x0_drop = 1'b0;
`endif

    // Scan alu_valid from rr_ptr upward with wrap; first set bit wins.
    always_comb begin
        int idx;
        scan_hit  = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (!scan_hit && bus.alu_valid[idx]) begin
                scan_hit  = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
    end

    // Clear pulse: every pending ALU on flush, else only the granted one; silent in reset.
    always_comb begin
        bus.alu_clear = '0;
        if (!rst_n) begin
            bus.alu_clear = '0;
        end else if (bus.flush) begin
            bus.alu_clear = bus.alu_valid;
        end else if (grant) begin
            bus.alu_clear[grant_idx] = 1'b1;
        end
    end

    // Hold-stage FSM, round-robin pointer and registered write-back / error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            rr_ptr        <= '0;
            bus.wb_rd     <= '0;
            bus.wb_data   <= '0;
            bus.wb_src    <= '0;
            bus.err_valid <= 1'b0;
            bus.err_src   <= '0;
            bus.err_rd    <= '0;
        end else if (bus.flush) begin
            state         <= EMPTY;
            bus.err_valid <= 1'b0;
        end else begin
            bus.err_valid <= 1'b0;
            if (grant) begin
                rr_ptr <= rr_next;
                if (g_err) begin
                    // A grant implies can_accept, so any held entry is drained this edge.
                    bus.err_valid <= 1'b1;
                    bus.err_src   <= grant_idx;
                    bus.err_rd    <= g_rd;
                    state         <= EMPTY;
                end else if (x0_drop) begin
                    state <= EMPTY;
                end else begin
                    bus.wb_rd   <= g_rd;
                    bus.wb_data <= g_res;
                    bus.wb_src  <= grant_idx;
                    state       <= FULL;
                end
            end else if (state == FULL && bus.wb_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_alu_commit_arbiter.sv
// Directed self-checking bench for alu_commit_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled away from the edge.
// Each scenario task carries its own hand-computed expectations.
module tb_alu_commit_arbiter;

    localparam int N    = 4;
    localparam int XLEN = core_config_pkg::XLEN;
    localparam int RW   = core_config_pkg::REG_ADDR_W;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_commit_arbiter_if #(.N_PORTS(N)) bus ();

    alu_commit_arbiter #(.N_PORTS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic [XLEN-1:0] res, input logic [RW-1:0] rd);
        bus.alu_res[i*XLEN +: XLEN] = res;
        bus.alu_rd[i*RW +: RW]      = rd;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.alu_res   = '0;
        bus.alu_rd    = '0;
        bus.alu_valid = 4'b1111;
        bus.alu_error = '0;
        bus.flush     = 1'b0;
        bus.wb_ready  = 1'b1;
        #3;
        checks++; if (bus.alu_clear !== 4'b0000) begin failures++; $display("FAIL reset_clear got=%b exp=0000", bus.alu_clear); end
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL reset_wb_en got=%b exp=0", bus.wb_en); end
        checks++; if (bus.wb_rd !== '0 || bus.wb_data !== '0 || bus.wb_src !== '0) begin failures++; $display("FAIL reset_wb_bus got rd=%0d data=%h src=%0d exp all 0", bus.wb_rd, bus.wb_data, bus.wb_src); end
        checks++; if (bus.err_valid !== 1'b0 || bus.err_src !== '0 || bus.err_rd !== '0) begin failures++; $display("FAIL reset_err got v=%b src=%0d rd=%0d exp all 0", bus.err_valid, bus.err_src, bus.err_rd); end
        tick();
        tick();
        bus.alu_valid = '0;
        rst_n         = 1'b1;
        tick();
    endtask

    task automatic test_single;
        set_port(0, 32'h0000_00AA, 5);
        bus.alu_valid = 4'b0001;
        #1;
        checks++; if (bus.alu_clear !== 4'b0001) begin failures++; $display("FAIL single_clear got=%b exp=0001", bus.alu_clear); end
        tick();
        bus.alu_valid = '0;
        checks++; if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'hAA || bus.wb_src !== 2'd0)
            begin failures++; $display("FAIL single_wb got en=%b rd=%0d data=%h src=%0d exp en=1 rd=5 data=aa src=0", bus.wb_en, bus.wb_rd, bus.wb_data, bus.wb_src); end
        tick();
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", bus.wb_en); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 0; i < N; i++) set_port(i, 32'h100 + i, RW'(i + 1));
        bus.alu_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [N-1:0] exp_clr;
            int g;
            g       = k % N;
            exp_clr = '0;
            exp_clr[g] = 1'b1;
            #1;
            checks++; if (bus.alu_clear !== exp_clr) begin failures++; $display("FAIL rr_clear[%0d] got=%b exp=%b", k, bus.alu_clear, exp_clr); end
            tick();
            checks++; if (bus.wb_en !== 1'b1 || bus.wb_src !== 2'(g) || bus.wb_data !== 32'h100 + g)
                begin failures++; $display("FAIL rr_wb[%0d] got en=%b src=%0d data=%h exp en=1 src=%0d data=%h", k, bus.wb_en, bus.wb_src, bus.wb_data, g, 32'h100 + g); end
        end
    endtask

    task automatic test_backpressure;
        // Hold stage holds port 0 (data 0x100, rd 1); rr_ptr is 1.
        bus.wb_ready  = 1'b0;
        bus.alu_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.alu_clear !== 4'b0000) begin failures++; $display("FAIL bp_clear[%0d] got=%b exp=0000", k, bus.alu_clear); end
            tick();
            checks++; if (bus.wb_en !== 1'b1 || bus.wb_src !== 2'd0 || bus.wb_data !== 32'h100 || bus.wb_rd !== 5'd1)
                begin failures++; $display("FAIL bp_hold[%0d] got en=%b src=%0d data=%h rd=%0d exp en=1 src=0 data=100 rd=1", k, bus.wb_en, bus.wb_src, bus.wb_data, bus.wb_rd); end
        end
        bus.wb_ready = 1'b1;
        #1;
        checks++; if (bus.alu_clear !== 4'b0010) begin failures++; $display("FAIL bp_release_clear got=%b exp=0010", bus.alu_clear); end
        tick();
        bus.alu_valid = '0;
        checks++; if (bus.wb_en !== 1'b1 || bus.wb_src !== 2'd1 || bus.wb_data !== 32'h101)
            begin failures++; $display("FAIL bp_release_wb got en=%b src=%0d data=%h exp en=1 src=1 data=101", bus.wb_en, bus.wb_src, bus.wb_data); end
        tick();
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus.wb_en); end
    endtask

    task automatic test_error;
        // rr_ptr is 2.
        set_port(2, 32'hDEAD_BEEF, 7);
        bus.alu_valid = 4'b0100;
        bus.alu_error = 4'b0100;
        #1;
        checks++; if (bus.alu_clear !== 4'b0100) begin failures++; $display("FAIL err_clear got=%b exp=0100", bus.alu_clear); end
        tick();
        bus.alu_valid = '0;
        bus.alu_error = '0;
        checks++; if (bus.err_valid !== 1'b1 || bus.err_src !== 2'd2 || bus.err_rd !== 5'd7)
            begin failures++; $display("FAIL err_commit got v=%b src=%0d rd=%0d exp v=1 src=2 rd=7", bus.err_valid, bus.err_src, bus.err_rd); end
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL err_wb_en got=%b exp=0", bus.wb_en); end
        tick();
        checks++; if (bus.err_valid !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", bus.err_valid); end
    endtask

    task automatic test_flush;
        // rr_ptr is 3: grant port 3 to fill the stage, leaving rr_ptr at 0.
        bus.alu_valid = 4'b1000;
        tick();
        checks++; if (bus.wb_en !== 1'b1 || bus.wb_src !== 2'd3) begin failures++; $display("FAIL flush_fill got en=%b src=%0d exp en=1 src=3", bus.wb_en, bus.wb_src); end
        bus.wb_ready  = 1'b0;
        bus.alu_valid = 4'b1011;
        bus.flush     = 1'b1;
        #1;
        checks++; if (bus.alu_clear !== 4'b1011) begin failures++; $display("FAIL flush_clear got=%b exp=1011", bus.alu_clear); end
        tick();
        bus.flush     = 1'b0;
        bus.wb_ready  = 1'b1;
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL flush_wb_en got=%b exp=0", bus.wb_en); end
        bus.alu_valid = 4'b1111;
        #1;
        checks++; if (bus.alu_clear !== 4'b0001) begin failures++; $display("FAIL flush_rr_kept got=%b exp=0001", bus.alu_clear); end
        tick();
        bus.alu_valid = '0;
        checks++; if (bus.wb_en !== 1'b1 || bus.wb_src !== 2'd0) begin failures++; $display("FAIL flush_after_wb got en=%b src=%0d exp en=1 src=0", bus.wb_en, bus.wb_src); end
    endtask

    task automatic test_async_reset;
        // Stage is FULL here; drop reset mid-cycle.
        bus.wb_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.wb_en !== 1'b0 || bus.err_valid !== 1'b0 || bus.wb_data !== '0)
            begin failures++; $display("FAIL async_reset got en=%b errv=%b data=%h exp en=0 errv=0 data=0", bus.wb_en, bus.err_valid, bus.wb_data); end
        tick();
        rst_n        = 1'b1;
        bus.wb_ready = 1'b1;
        bus.alu_valid = 4'b1111;
        #1;
        checks++; if (bus.alu_clear !== 4'b0001) begin failures++; $display("FAIL async_rr_start got=%b exp=0001", bus.alu_clear); end
        set_port(0, 32'h55, 0);
        bus.alu_valid = 4'b0001;
        #1;
        checks++; if (bus.alu_clear !== 4'b0001) begin failures++; $display("FAIL x0_clear got=%b exp=0001", bus.alu_clear); end
        tick();
        bus.alu_valid = 4'b0011;
`ifdef ALU_COMMIT_X0_DROP_EN
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL x0_drop got en=%b exp=0", bus.wb_en); end
`else
        checks++; if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'h55)
            begin failures++; $display("FAIL x0_pass got en=%b rd=%0d data=%h exp en=1 rd=0 data=55", bus.wb_en, bus.wb_rd, bus.wb_data); end
`endif
        #1;
        checks++; if (bus.alu_clear !== 4'b0010) begin failures++; $display("FAIL x0_rr_adv got=%b exp=0010", bus.alu_clear); end
        tick();
        bus.alu_valid = '0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_error();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_commit_arbiter.md
Name: alu_commit_arbiter

Overview:
- Shares the single register-file write-back port between N_PORTS ALU commit interfaces (res/o_rd/valid/o_error/clear).
- Round-robin grant with a one-entry output holding stage.
- Pulses the granted ALU's clear so the ALU can accept its next operation.
- Routes ALU error results to a separate error/trap port instead of write-back.

Parameters:
- N_PORTS, 4, number of ALU commit interfaces (2..8).
- XLEN, core_config_pkg::XLEN, data width.
- REG_ADDR_W, core_config_pkg::REG_ADDR_W, destination register index width.
- SRC_W, $clog2(N_PORTS), width of source-index outputs.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_res  in  N_PORTS*XLEN  packed ALU results; port i at [i*XLEN +: XLEN].
- alu_rd  in  N_PORTS*REG_ADDR_W  packed destination registers.
- alu_valid  in  N_PORTS  ALU result valid.
- alu_error  in  N_PORTS  ALU result error flag (o_error).
- alu_clear  out  N_PORTS  one-cycle clear pulse to ALU i.
- flush  in  1  synchronous pipeline flush.
- wb_ready  in  1  write-back consumer accepts this cycle.
- wb_en  out  1  write-back valid.
- wb_rd  out  REG_ADDR_W  write-back register index.
- wb_data  out  XLEN  write-back data.
- wb_src  out  SRC_W  ALU index that produced wb_data.
- err_valid  out  1  error-commit pulse.
- err_src  out  SRC_W  ALU index that raised the error.
- err_rd  out  REG_ADDR_W  destination of the faulting op.

Behaviour:
- Reset (rst_n low, async): wb_en=0, wb_rd=0, wb_data=0, wb_src=0, err_valid=0, err_src=0, err_rd=0, rr_ptr=0, state=EMPTY. alu_clear is combinational and reads 0 during reset.
- Hold stage has two states, EMPTY and FULL.
  - wb_en = (state==FULL). wb_rd, wb_data and wb_src are registered and stable while FULL && !wb_ready.
- can_accept = (state==EMPTY) || wb_ready.
- Grant (combinational):
  - When can_accept is high, scan alu_valid starting at rr_ptr upward, wrapping modulo N_PORTS. The first set bit is g.
  - If no bit is set, there is no grant.
- On grant, in the same cycle:
  - alu_clear[g]=1 (combinational, exactly that cycle; all other bits 0).
  - At the edge:
    - rr_ptr <= (g+1) mod N_PORTS.
    - If alu_error[g]=0: capture alu_res[g], alu_rd[g] and g into the hold stage; state <= FULL.
    - If alu_error[g]=1: nothing enters the hold stage. err_valid <= 1, err_src <= g, err_rd <= alu_rd[g]. state <= EMPTY if wb_ready consumed, else unchanged.
- err_valid is a single-cycle pulse; it deasserts the cycle after unless a new error grant occurs.
- No grant while can_accept is high: if FULL && wb_ready then state <= EMPTY. rr_ptr is unchanged.
- FULL && wb_ready && grant: back-to-back. The new entry replaces the old one at the same edge, giving sustained throughput of 1 commit/cycle.
- Latency: ALU valid seen at cycle T gives wb_en at T+1 (empty stage, no contention).
- Fairness: a continuously valid port waits at most N_PORTS-1 grants.
- Flush (high for a cycle):
  - state <= EMPTY; err_valid <= 0; rr_ptr unchanged.
  - alu_clear = alu_valid (every pending ALU is cleared) that cycle.
  - No grant is made.
  - Flush has priority over grant and over wb_ready.
- Reset asserted mid-operation: the hold contents are lost and no clear is issued. ALUs reset from the same rst_n.
- Invariant: at most one alu_clear bit is set except during flush.

Optional Feature:
- Macro: ALU_COMMIT_X0_DROP_EN.
- Defined:
  - A non-error grant with alu_rd[g]==0 is still granted: clear pulse issued and rr_ptr advanced.
  - It is not captured: state stays EMPTY (or drains as if there were no grant).
  - Writes to x0 therefore never reach wb_en.
- Undefined: x0 results are presented on wb_en like any other register. The register file is responsible for ignoring them.

Test Plan:
- Single commit: alu_valid=0001, alu_res[0]=0x0000_00AA, alu_rd[0]=5, wb_ready=1 -> alu_clear=0001 in the same cycle; next cycle wb_en=1, wb_rd=5, wb_data=0xAA, wb_src=0.
- Round-robin: all four valid continuously, wb_ready=1, rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; wb_en held high 5 cycles.
- Backpressure: FULL with wb_ready=0 for 3 cycles while alu_valid=0010 -> alu_clear stays 0000 and wb_* stay stable. When wb_ready=1: port 1 is cleared and presented the next cycle.
- Error: alu_valid=0100, alu_error=0100, alu_rd[2]=7 -> alu_clear=0100; next cycle err_valid=1, err_src=2, err_rd=7, wb_en=0; err_valid=0 the cycle after.
- Flush: FULL, alu_valid=1011, flush=1 -> alu_clear=1011; next cycle wb_en=0, rr_ptr unchanged.
- Async reset during FULL: rst_n low mid-cycle -> wb_en=0 and err_valid=0 immediately; after release, first grant starts at port 0. With ALU_COMMIT_X0_DROP_EN, alu_rd[0]=0 -> clear issued, wb_en stays 0.
